// File: rtl/fetch_prefetch.sv
// fetch_prefetch: prefetching instruction fetch unit for the RV32I pipeline.
// Keeps up to MAX_OUTSTANDING memory reads in flight, queues returned words
// with their PCs, and hands them to decode over a valid/ready handshake.
// Redirects flush the queue and discard responses to requests already in flight.
module fetch_prefetch #(
    parameter logic [31:0] PC_RESET        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] main_memory_instr_addr,
    output logic        main_memory_instr_req,
    input  logic [31:0] main_memory_instr,
    input  logic        main_memory_instr_ack,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    input  logic        execute_change_pc,
    input  logic [31:0] execute_next_pc,
    input  logic        writeback_change_pc,
    input  logic [31:0] writeback_next_pc
);
    localparam int unsigned QW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PW-1:0] PEND_LAST = PW'(MAX_OUTSTANDING - 1);

    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;
    logic [CW-1:0] count_q, count_d;
    logic [QW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OW-1:0] out_q, out_d, drop_q, drop_d;
    logic [PW-1:0] pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;

    logic [31:0]   q_instr_q [FIFO_DEPTH];
    logic [31:0]   q_pc_q    [FIFO_DEPTH];
    logic [31:0]   pend_pc_q [MAX_OUTSTANDING];

    logic          redirect, ack, push, pop, issue;
    logic [31:0]   target;
    logic [OW-1:0] out_after_ack, live;
    int unsigned   credit_used;

    assign fetch_valid            = (count_q != '0);
    assign fetch_instr            = fetch_valid ? q_instr_q[rd_ptr_q] : '0;
    assign fetch_pc               = fetch_valid ? q_pc_q[rd_ptr_q] : '0;
    assign main_memory_instr_req  = req_q;
    assign main_memory_instr_addr = addr_q;

    // Issue decision, queue bookkeeping and redirect handling.
    always_comb begin
        redirect    = execute_change_pc | writeback_change_pc;
        target      = writeback_change_pc ? writeback_next_pc : execute_next_pc;
        target[1:0] = 2'b00;
        ack         = main_memory_instr_ack;
        pop         = fetch_valid & fetch_ready;
        push        = ack & (drop_q == '0) & ~redirect;

        // A same-cycle ack frees its slot, so L+1 slots sustain one req per cycle.
        out_after_ack = out_q - OW'(ack);
        // Live in-flight words plus queued words never exceed the queue size.
        live          = out_q - drop_q;
        credit_used   = 32'(live) + 32'(count_q);
        issue         = ~redirect && (credit_used < FIFO_DEPTH)
                        && (32'(out_after_ack) < MAX_OUTSTANDING);

        req_d    = issue;
        addr_d   = addr_q;
        req_pc_d = req_pc_q;
        if (redirect) begin
            req_pc_d = target;
        end else if (issue) begin
            addr_d   = req_pc_q;
            req_pc_d = req_pc_q + 32'd4;
        end

        out_d  = out_after_ack + OW'(issue);
        drop_d = drop_q;
        if (redirect) begin
            drop_d = out_after_ack;
        end else if (ack && (drop_q != '0)) begin
            drop_d = drop_q - OW'(1);
        end

        count_d  = count_q + CW'(push) - CW'(pop);
        rd_ptr_d = rd_ptr_q + QW'(pop);
        wr_ptr_d = wr_ptr_q + QW'(push);
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end

        // PC tags follow every request, dropped or not, so they stay aligned.
        pend_wr_d = pend_wr_q;
        pend_rd_d = pend_rd_q;
        if (issue) pend_wr_d = (pend_wr_q == PEND_LAST) ? '0 : pend_wr_q + PW'(1);
        if (ack)   pend_rd_d = (pend_rd_q == PEND_LAST) ? '0 : pend_rd_q + PW'(1);
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_pc_q  <= PC_RESET;
            addr_q    <= PC_RESET;
            req_q     <= 1'b0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            out_q     <= '0;
            drop_q    <= '0;
            pend_rd_q <= '0;
            pend_wr_q <= '0;
        end else begin
            req_pc_q  <= req_pc_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
            pend_rd_q <= pend_rd_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    // Data storage for the instruction queue and in-flight PC tags.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr_q[wr_ptr_q] <= main_memory_instr;
            q_pc_q[wr_ptr_q]    <= pend_pc_q[pend_rd_q];
        end
        if (issue) begin
            pend_pc_q[pend_wr_q] <= req_pc_q;
        end
    end

endmodule
